// File: rtl/lc4_dmem_arbiter.sv
// lc4_dmem_arbiter: shares lc4_memory's data port between the LC4 core (port 0) and the
// scrub/DMA engine (port 1) with round-robin, bounded burst lock and tagged read return.
module lc4_dmem_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gwe,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic          r0_lock,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic          r1_lock,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_dwe,
    output logic          mem_dre,
    input  logic [DW-1:0] mem_dout
);
    typedef enum logic [1:0] {ARB, LOCKED, RELEASE} state_t;

    state_t     state, state_nx;
    logic       last, last_nx, owner, owner_nx;
    logic       en, own_req, own_lock, we;
    logic [7:0] cnt, cnt_nx;
    logic       tag_v  [READ_LATENCY];
    logic       tag_id [READ_LATENCY];

    assign en       = gwe & rst;
    assign own_req  = owner ? r1_req : r0_req;
    assign own_lock = owner ? r1_lock : r0_lock;

    // In RELEASE the owner plays the role of "last" so the other port gets priority.
    always_comb begin
        r0_gnt   = 1'b0;
        r1_gnt   = 1'b0;
        state_nx = state;
        last_nx  = last;
        owner_nx = owner;
        cnt_nx   = cnt;
        if (en) begin
            case (state)
                ARB: begin
                    r0_gnt = r0_req & (last | ~r1_req);
                    r1_gnt = r1_req & (~last | ~r0_req);
                    if (r0_gnt | r1_gnt) last_nx = r1_gnt;
                    if ((r0_gnt & r0_lock) | (r1_gnt & r1_lock)) begin
                        state_nx = LOCKED;
                        owner_nx = r1_gnt;
                        cnt_nx   = 8'd1;
                    end
                end
                LOCKED: begin
                    r0_gnt = ~owner & r0_req;
                    r1_gnt = owner & r1_req;
                    if (!own_lock) state_nx = ARB;
                    else if (own_req && cnt == 8'(MAX_BURST - 1)) state_nx = RELEASE;
                    else if (own_req) cnt_nx = cnt + 8'd1;
                end
                RELEASE: begin
                    r0_gnt   = r0_req & (owner | ~r1_req);
                    r1_gnt   = r1_req & (~owner | ~r0_req);
                    state_nx = ARB;
                    if (r0_gnt | r1_gnt) last_nx = r1_gnt;
                end
                default: state_nx = ARB;
            endcase
        end
    end

    assign we       = r1_gnt ? r1_we : r0_we;
    assign mem_addr = r1_gnt ? r1_addr : r0_addr;
    assign mem_din  = r1_gnt ? r1_wdata : r0_wdata;
    assign mem_dwe  = (r0_gnt | r1_gnt) & we;
    assign mem_dre  = (r0_gnt | r1_gnt) & ~we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB;
            last  <= 1'b1;
            owner <= 1'b0;
            cnt   <= 8'd0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= 1'b0;
            end
        end else if (gwe) begin
            state     <= state_nx;
            last      <= last_nx;
            owner     <= owner_nx;
            cnt       <= cnt_nx;
            tag_v[0]  <= mem_dre;
            tag_id[0] <= r1_gnt;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign r0_rvalid = tag_v[READ_LATENCY-1] & ~tag_id[READ_LATENCY-1];
    assign r1_rvalid = tag_v[READ_LATENCY-1] & tag_id[READ_LATENCY-1];
    assign r0_rdata  = rst ? mem_dout : '0;
    assign r1_rdata  = rst ? mem_dout : '0;
endmodule

// File: tb/tb_lc4_dmem_arbiter.sv
// tb_lc4_dmem_arbiter: directed stimulus on two arbiters (READ_LATENCY 1 and 3) sharing inputs;
// read data is checked by a queue scoreboard fed at grant time and drained by a monitor.
module tb_lc4_dmem_arbiter;
    logic        clk = 0, rst = 0, gwe = 1;
    logic        r0_req = 0, r0_we = 0, r0_lock = 0, r1_req = 0, r1_we = 0, r1_lock = 0;
    logic [15:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
    logic        a_r0_gnt, a_r0_rvalid, a_r1_gnt, a_r1_rvalid, a_mem_dwe, a_mem_dre;
    logic        b_r0_gnt, b_r0_rvalid, b_r1_gnt, b_r1_rvalid, b_mem_dwe, b_mem_dre;
    logic [15:0] a_r0_rdata, a_r1_rdata, a_mem_addr, a_mem_din, a_mem_dout;
    logic [15:0] b_r0_rdata, b_r1_rdata, b_mem_addr, b_mem_din, b_mem_dout;
    int          checks = 0, errors = 0;
    logic [15:0] q [4][$];
    logic [15:0] mem [256];
    bit          wr [256];
    logic [15:0] a_pipe;
    logic [15:0] b_pipe [3];

    always #5 clk = ~clk;

    lc4_dmem_arbiter #(.READ_LATENCY(1), .MAX_BURST(8)) dut_a (
        .clk(clk), .rst(rst), .gwe(gwe),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(a_r0_gnt), .r0_rvalid(a_r0_rvalid), .r0_rdata(a_r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(a_r1_gnt), .r1_rvalid(a_r1_rvalid), .r1_rdata(a_r1_rdata),
        .mem_addr(a_mem_addr), .mem_din(a_mem_din), .mem_dwe(a_mem_dwe), .mem_dre(a_mem_dre),
        .mem_dout(a_mem_dout));

    lc4_dmem_arbiter #(.READ_LATENCY(3), .MAX_BURST(8)) dut_b (
        .clk(clk), .rst(rst), .gwe(gwe),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(b_r0_gnt), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(b_r1_gnt), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
        .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_dwe(b_mem_dwe), .mem_dre(b_mem_dre),
        .mem_dout(b_mem_dout));

    function automatic logic [15:0] rd_mem(input logic [15:0] ad);
        logic [7:0] i;
        i = ad[7:0];
        if (wr[i]) return mem[i];
        return i == 8'h10 ? 16'hAAAA : i == 8'h20 ? 16'h5555 : {i, ~i};
    endfunction

    // Memory models with read latency matching each instance, advancing only on gwe.
    always @(posedge clk) begin
        if (gwe) begin
            a_pipe    <= rd_mem(a_mem_addr);
            b_pipe[0] <= rd_mem(b_mem_addr);
            b_pipe[1] <= b_pipe[0];
            b_pipe[2] <= b_pipe[1];
            if (a_mem_dwe) begin
                mem[a_mem_addr[7:0]] <= a_mem_din;
                wr[a_mem_addr[7:0]]  <= 1'b1;
            end
        end
    end
    assign a_mem_dout = a_pipe;
    assign b_mem_dout = b_pipe[2];

    // Monitor: every rvalid accepted (gwe=1) must match the oldest expected read for that port.
    always @(negedge clk) begin
        logic [3:0]  rv;
        logic [15:0] rd [4];
        logic [15:0] e;
        rv = {b_r1_rvalid, b_r0_rvalid, a_r1_rvalid, a_r0_rvalid};
        rd[0] = a_r0_rdata; rd[1] = a_r1_rdata; rd[2] = b_r0_rdata; rd[3] = b_r1_rdata;
        if (rst && gwe) begin
            for (int k = 0; k < 4; k++) begin
                if (rv[k]) begin
                    checks++;
                    if (q[k].size() == 0) begin
                        errors++;
                        $display("FAIL rvalid_%0d: got valid with data %h, required no valid", k, rd[k]);
                    end else begin
                        e = q[k].pop_front();
                        if (rd[k] !== e) begin
                            errors++;
                            $display("FAIL rdata_%0d: got %h, required %h", k, rd[k], e);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, required %h", n, $time, act, exp);
        end
    endtask

    task automatic set0(input logic req, we, lock, input logic [15:0] ad, dt);
        r0_req = req; r0_we = we; r0_lock = lock; r0_addr = ad; r0_wdata = dt;
    endtask

    task automatic set1(input logic req, we, lock, input logic [15:0] ad, dt);
        r1_req = req; r1_we = we; r1_lock = lock; r1_addr = ad; r1_wdata = dt;
    endtask

    // One cycle: expected grants, expected rvalids (-1 = don't care) for instance a and b port0/1.
    task automatic cyc(input logic e0, e1, input int v0, v1, vb0, vb1);
        logic        w, we;
        logic [15:0] ad, dn;
        @(negedge clk);
        #1;
        w  = e1;
        we = w ? r1_we : r0_we;
        ad = w ? r1_addr : r0_addr;
        dn = w ? r1_wdata : r0_wdata;
        chk("a_gnt", {a_r0_gnt, a_r1_gnt}, {e0, e1});
        chk("b_gnt", {b_r0_gnt, b_r1_gnt}, {e0, e1});
        chk("mem_dwe", a_mem_dwe, (e0 | e1) & we);
        chk("mem_dre", a_mem_dre, (e0 | e1) & ~we);
        if (e0 | e1) begin
            chk("mem_addr", a_mem_addr, ad);
            chk("mem_din", a_mem_din, dn);
            if (!we) begin
                q[int'(w)].push_back(rd_mem(ad));
                q[int'(w) + 2].push_back(rd_mem(ad));
            end
        end
        if (v0 >= 0) chk("a_r0_rvalid", a_r0_rvalid, v0[0]);
        if (v1 >= 0) chk("a_r1_rvalid", a_r1_rvalid, v1[0]);
        if (vb0 >= 0) chk("b_r0_rvalid", b_r0_rvalid, vb0[0]);
        if (vb1 >= 0) chk("b_r1_rvalid", b_r1_rvalid, vb1[0]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        set0(1, 0, 0, 16'h10, 0);
        set1(1, 0, 1, 16'h20, 0);
        #2;
        chk("reset_gnt", {a_r0_gnt, a_r1_gnt, b_r0_gnt, b_r1_gnt}, 0);
        chk("reset_rvalid", {a_r0_rvalid, a_r1_rvalid, b_r0_rvalid, b_r1_rvalid}, 0);
        chk("reset_mem_we_re", {a_mem_dwe, a_mem_dre}, 0);
        chk("reset_rdata", {a_r0_rdata, a_r1_rdata}, 0);
        @(posedge clk);
        #1;
        rst = 1;
        // Simultaneous reads: r0 wins the first tie, results routed only to their issuer
        set0(1, 0, 0, 16'h10, 0);
        set1(1, 0, 0, 16'h20, 0);
        cyc(1, 0, 0, 0, 0, 0);
        set0(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        // Back-to-back writes alternate
        for (int i = 0; i < 4; i++) begin
            set0(1, 1, 0, 16'h30 + 16'(i), 16'h1100 + 16'(i));
            set1(1, 1, 0, 16'h40 + 16'(i), 16'h2200 + 16'(i));
            cyc(logic'(i % 2 == 0), logic'(i % 2 == 1), 0, int'(i == 0), -1, -1);
        end
        // r1 burst lock of 8 reads while r0 keeps writing
        set0(1, 1, 0, 16'h60, 16'h3333);
        set1(1, 0, 1, 16'h50, 0);
        cyc(1, 0, 0, 0, -1, -1);
        for (int i = 0; i < 8; i++) begin
            set1(1, 0, 1, 16'h50 + 16'(i), 0);
            cyc(0, 1, 0, int'(i > 0), -1, -1);
        end
        cyc(1, 0, 0, 1, -1, -1);
        set1(1, 0, 0, 16'h5a, 0);
        cyc(0, 1, 0, 0, -1, -1);
        cyc(1, 0, 0, 1, -1, -1);
        // r0 holds lock without requesting: r1 starves until the lock drops
        set1(0, 0, 0, 0, 0);
        set0(1, 0, 1, 16'h10, 0);
        cyc(1, 0, 0, 0, -1, -1);
        set0(0, 0, 1, 16'h10, 0);
        set1(1, 0, 0, 16'h20, 0);
        cyc(0, 0, 1, 0, -1, -1);
        cyc(0, 0, 0, 0, -1, -1);
        set0(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, -1, -1);
        cyc(0, 1, 0, 0, -1, -1);
        // gwe stall with a read in flight at latency 3
        set0(1, 0, 0, 16'h10, 0);
        set1(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, -1, -1);
        gwe = 0;
        set0(0, 0, 0, 0, 0);
        set1(1, 0, 0, 16'h20, 0);
        cyc(0, 0, -1, -1, 0, -1);
        gwe = 1;
        set1(0, 0, 0, 0, 0);
        cyc(0, 0, -1, -1, 0, -1);
        cyc(0, 0, 0, 0, 0, -1);
        // Lock with two reads in flight, then reset drops everything
        set1(1, 0, 1, 16'h30, 0);
        cyc(0, 1, 0, 0, 1, -1);
        set1(1, 0, 1, 16'h31, 0);
        cyc(0, 1, 0, 1, 0, -1);
        rst = 0;
        #1;
        chk("rst_mid_gnt", {a_r0_gnt, a_r1_gnt, b_r0_gnt, b_r1_gnt}, 0);
        chk("rst_mid_rvalid", {a_r0_rvalid, a_r1_rvalid, b_r0_rvalid, b_r1_rvalid}, 0);
        chk("rst_mid_mem_we_re", {a_mem_dwe, a_mem_dre, b_mem_dwe, b_mem_dre}, 0);
        chk("rst_mid_rdata", {b_r0_rdata, b_r1_rdata}, 0);
        for (int k = 0; k < 4; k++) q[k].delete();
        @(posedge clk);
        #1;
        rst = 1;
        set0(1, 0, 0, 16'h20, 0);
        set1(1, 0, 1, 16'h10, 0);
        cyc(1, 0, 0, 0, 0, 0);
        set0(0, 0, 0, 0, 0);
        set1(1, 0, 0, 16'h10, 0);
        cyc(0, 1, 1, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, -1, -1, -1, -1);
        chk("queues_drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lc4_dmem_arbiter.md
Name: lc4_dmem_arbiter

Overview:
- Shares the single data port of lc4_memory (daddr/din/dout/dwe/dre) between two requesters: port 0 is the LC4 core load/store unit, port 1 is the ECC scrub/DMA engine.
- Arbitrates round-robin, with an optional bounded burst lock.
- Tracks in-flight reads through a tag pipeline so each read result returns only to its issuer.
- Sits between the pipeline/engine and lc4_memory and is clocked with the same global write-enable discipline.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- READ_LATENCY, 1, cycles from mem_dre to valid mem_dout; legal range 1..8.
- MAX_BURST, 8, maximum consecutive grants to one locked owner; legal range 2..255.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- gwe  in  1  global write enable; all state advances only when gwe=1.
- r0_req  in  1  port 0 request.
- r0_we  in  1  port 0 write (1) / read (0).
- r0_lock  in  1  port 0 requests burst lock.
- r0_addr  in  AW  port 0 address.
- r0_wdata  in  DW  port 0 write data.
- r0_gnt  out  1  port 0 request accepted this cycle.
- r0_rvalid  out  1  port 0 read data valid.
- r0_rdata  out  DW  port 0 read data.
- r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as port 0, for port 1.
- mem_addr  out  AW  to lc4_memory daddr.
- mem_din  out  DW  to lc4_memory din.
- mem_dwe  out  1  to lc4_memory dwe.
- mem_dre  out  1  to lc4_memory dre.
- mem_dout  in  DW  from lc4_memory dout.

Behaviour:
- Reset (rst=0, async):
  - state=ARB, last=1 (port 0 wins the first tie), burst_cnt=0, tag pipe cleared.
  - All gnt/rvalid/mem_dwe/mem_dre=0; rdata=0.
- Grant is combinational from req and registered state; the access is issued the same cycle. Accept = gnt.
- gwe=0: both gnt=0, mem_dwe=mem_dre=0, no state or tag-pipe update.
- States:
  - ARB, one requester: that requester is granted.
  - ARB, both requesting: the port != last is granted.
  - Any grant in ARB: last<=winner.
  - Grant with lock=1: go to LOCKED(owner=winner), burst_cnt<=1.
  - LOCKED: only the owner can be granted; the other port's gnt=0 even if it requests.
    - Owner grant with lock=1 and burst_cnt<MAX_BURST-1: stay, burst_cnt+1.
    - Owner grant with lock=0: go to ARB.
    - Owner grant with burst_cnt=MAX_BURST-1: go to RELEASE.
    - Owner req=0 and lock=0: go to ARB.
    - Owner req=0 and lock=1: hold the lock, no grant, burst_cnt unchanged.
  - RELEASE (one cycle): the non-owner is granted if requesting and lock is ignored; otherwise the owner may be granted without re-locking. Next state is ARB, with normal last update.
- Mux:
  - mem_addr/mem_din = winner's addr/wdata, or port 0 values when idle (don't-care).
  - mem_dwe = gnt&we.
  - mem_dre = gnt&~we.
- Read return:
  - Tag pipe of READ_LATENCY stages, each stage {valid, id}; it shifts when gwe=1.
  - Stage 0 loads {mem_dre, winner}.
  - The tail stage drives rX_rvalid = valid & (id==X).
  - r0_rdata = r1_rdata = mem_dout (validity is indicated only by rvalid).
- Writes return nothing. Reads and writes may interleave back-to-back with no bubbles; throughput is 1 access/cycle.
- Reset mid-burst or with reads in flight: lock and tags are dropped, and no rvalid is ever produced for them.
- Simultaneous lock request from both in ARB: only the winner locks.

Test Plan:
- Reset, then r0 read 0x0010 and r1 read 0x0020 asserted together (READ_LATENCY=1, mem returns 0xAAAA then 0x5555) -> r0_gnt in cycle 1 and r1_gnt in cycle 2; r0_rvalid with 0xAAAA one cycle after its grant; r1_rvalid with 0x5555 one cycle later; no cross-valid.
- Both ports continuously request writes -> grants alternate 0,1,0,1; mem_dwe=1 every cycle; mem_addr/mem_din match the winner each cycle.
- r1 locks with continuous requests, r0 also requesting, MAX_BURST=8 -> exactly 8 consecutive r1 grants, then one r0 grant in RELEASE, then round-robin resumes.
- gwe pulsed 1,0,1 with a read in flight at READ_LATENCY=3 -> no grants while gwe=0; rvalid appears after 3 gwe=1 edges, not 3 clocks.
- rst asserted mid-lock with 2 reads in flight -> all outputs 0 immediately; after release no stale rvalid; first tie goes to r0.
- r0 locked, r0_req drops with lock=1 while r1 requests -> r1_gnt stays 0 until r0 drops lock, then r1 is granted the next cycle.
